// File: rtl/ahb_wait_sram.sv
// AHB-Lite subordinate SRAM with configurable wait states, lane-strobed writes,
// two-cycle ERROR responses and write-to-read forwarding for back-to-back beats.
module ahb_wait_sram #(
  parameter int unsigned             AddressWidth = 32,
  parameter int unsigned             DataWidth    = 32,
  parameter int unsigned             DepthWords   = 1024,
  parameter logic [AddressWidth-1:0] BaseAddress  = '0,
  parameter int unsigned             WaitStates   = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [AddressWidth-1:0] HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [DataWidth-1:0]    HWDATA,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DataWidth-1:0]    HRDATA
);

  localparam int unsigned     Bw       = DataWidth / 8;
  localparam int unsigned     OffW     = $clog2(Bw);
  localparam int unsigned     IdxW     = (DepthWords > 1) ? $clog2(DepthWords) : 1;
  localparam longint unsigned MemBytes = 64'(DepthWords) * 64'(Bw);

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  logic [DataWidth-1:0] mem [DepthWords];

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 dp_valid_q, dp_valid_d;
  logic                 dp_write_q, dp_write_d;
  logic [IdxW-1:0]      dp_idx_q, dp_idx_d;
  logic [Bw-1:0]        dp_lanes_q, dp_lanes_d;
  logic [DataWidth-1:0] hrdata_q, hrdata_d;

  logic [AddressWidth-1:0] offset;
  logic                    range_err, size_err, align_err, req_err;
  logic                    accept, commit, fetch;
  logic [IdxW-1:0]         req_idx, fetch_idx;
  logic [Bw-1:0]           req_lanes;
  logic [DataWidth-1:0]    fetch_word;
  logic                    unused_inputs;

  assign unused_inputs = ^{HBURST, HTRANS[0]};

  // Address-phase decode
  always_comb begin
    offset    = HADDR - BaseAddress;
    range_err = 64'(offset) >= MemBytes;
    size_err  = HSIZE > 3'(OffW);
    align_err = (32'(offset[OffW-1:0]) & ((32'd1 << HSIZE) - 32'd1)) != 32'd0;
    req_err   = range_err | size_err | align_err;
    req_idx   = offset[OffW +: IdxW];
    req_lanes = Bw'(((32'd1 << (32'd1 << HSIZE)) - 32'd1) << offset[OffW-1:0]);
  end

  assign HREADYOUT = !((state_q == StErr1) || ((state_q == StWait) && (cnt_q != 4'd0)));
  assign HRESP     = (state_q == StErr1) || (state_q == StErr2);
  assign HRDATA    = hrdata_q;

  assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign commit = HREADYOUT & dp_valid_q & dp_write_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_lanes_d = dp_lanes_q;
    hrdata_d   = hrdata_q;
    fetch      = 1'b0;
    fetch_idx  = dp_idx_q;

    case (state_q)
      StErr1: state_d = StErr2;
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          // Read data is fetched on the last wait edge so it is stable in the ready cycle
          if ((cnt_q == 4'd1) && dp_valid_q && !dp_write_q) begin
            fetch = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (HREADYOUT) begin
      state_d    = StIdle;
      dp_valid_d = 1'b0;
      if (accept) begin
        if (req_err) begin
          state_d = StErr1;
          if (!HWRITE) begin
            hrdata_d = '0;
          end
        end else begin
          dp_valid_d = 1'b1;
          dp_write_d = HWRITE;
          dp_idx_d   = req_idx;
          dp_lanes_d = req_lanes;
          if (WaitStates == 0) begin
            if (!HWRITE) begin
              fetch     = 1'b1;
              fetch_idx = req_idx;
            end
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WaitStates);
          end
        end
      end
    end

    // Merge lanes of a write committing on the same edge so reads never see stale data
    fetch_word = mem[fetch_idx];
    for (int b = 0; b < Bw; b++) begin
      if (commit && (dp_idx_q == fetch_idx) && dp_lanes_q[b]) begin
        fetch_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
    if (fetch) begin
      hrdata_d = fetch_word;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_lanes_q <= '0;
      hrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      dp_lanes_q <= dp_lanes_d;
      hrdata_q   <= hrdata_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < Bw; b++) begin
        if (dp_lanes_q[b]) begin
          mem[dp_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule
